sam_stream_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares the single SAM datapath stream input among NUM_REQ AXI-stream requesters.
- A requester holds the grant from its first beat to its last (in_last) beat; packets are never interleaved.
- Output passes through an internal 2-entry skid buffer and carries the source index (m_id) with every beat so downstream logic can route results back.
- Sits between the requester streams and the SAM datapath input.

---
 rtl/sam_pkg.sv | 25 ++
 rtl/sam_skid_buffer.sv | 49 ++++
 rtl/sam_stream_arbiter.sv | 142 ++++++++++++++
 tb/tb_sam_stream_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sam_pkg.sv
// Shared definitions for the SAM stream blocks: arbiter state encoding,
// default datapath width and a constant clog2 helper.
package sam_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  localparam int unsigned SAM_DATA_W = 32;

  // Ceiling log2 for elaboration-time sizing; clog2(0) and clog2(1) return 0
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 1) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sam_skid_buffer.sv
// Two-entry skid buffer with registered outputs: a holding register plus one
// overflow slot, giving full throughput and a registered input ready.
module sam_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_q;
  logic             skid_valid_q;
  logic             push;
  logic             load;

  assign in_ready = ~skid_valid_q;
  assign push     = in_valid & in_ready;
  assign load     = ~out_valid | out_ready;

  // Output register refills from the overflow slot first so ordering is kept
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (load) begin
      if (skid_valid_q) begin
        out_data     <= skid_q;
        out_valid    <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) begin
          out_data <= in_data;
        end
      end
    end else if (push) begin
      skid_q       <= in_data;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/sam_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the SAM datapath input among
// NUM_REQ requester streams; each beat is tagged with its source index.
module sam_stream_arbiter
  import sam_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = SAM_DATA_W,
  parameter int unsigned ID_W    = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] s_data,
  input  logic [NUM_REQ-1:0]        s_valid,
  input  logic [NUM_REQ-1:0]        s_last,
  output logic [NUM_REQ-1:0]        s_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_valid,
  output logic                      m_last,
  output logic [ID_W-1:0]           m_id,
  input  logic                      m_ready,
  output logic                      busy,
  output logic [31:0]               pkt_cnt
);

  localparam int unsigned PAY_W = DATA_W + 1 + ID_W;

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     pick;
  logic [NUM_REQ-1:0]  req_rot;
  logic                any_req;
  logic                sel_valid;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;
  logic                xfer_valid;
  logic                skid_in_ready;
  logic [PAY_W-1:0]    skid_out;

  // Mux the granted requester's beat
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_valid = s_valid[i];
        sel_last  = s_last[i];
        sel_data  = s_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // First requesting index at or after rr_ptr, found on a rotated request vector
  always_comb begin : rr_pick
    logic        found;
    int unsigned sum;
    found   = 1'b0;
    sum     = 0;
    pick    = '0;
    any_req = |s_valid;
    req_rot = NUM_REQ'({s_valid, s_valid} >> rr_ptr_q);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = 32'(rr_ptr_q) + i;
        if (sum >= NUM_REQ) begin
          sum = sum - NUM_REQ;
        end
        pick = ID_W'(sum);
      end
    end
  end

  assign xfer_valid = (state_q == ARB_XFER) & sel_valid;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    s_ready  = '0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant_q == ID_W'(i)) begin
            s_ready[i] = skid_in_ready;
          end
        end
        // Finishing requester drops to lowest priority for the next round
        if (xfer_valid && skid_in_ready && sel_last) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  sam_skid_buffer #(
    .WIDTH(PAY_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({sel_last, grant_q, sel_data}),
    .in_valid (xfer_valid),
    .in_ready (skid_in_ready),
    .out_data (skid_out),
    .out_valid(m_valid),
    .out_ready(m_ready)
  );

  assign {m_last, m_id, m_data} = skid_out;
  assign busy = (state_q == ARB_XFER);

  // Packets counted as they leave on the datapath side
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (m_valid && m_ready && m_last) begin
      pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_sam_stream_arbiter.sv
// Bench for sam_stream_arbiter: directed steps plus randomized traffic checked
// against a packet-level round-robin model built from per-requester queues.
module tb_sam_stream_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ*DATA_W-1:0] s_data;
  logic [NUM_REQ-1:0]        s_valid;
  logic [NUM_REQ-1:0]        s_last;
  logic [NUM_REQ-1:0]        s_ready;
  logic [DATA_W-1:0]         m_data;
  logic                      m_valid;
  logic                      m_last;
  logic [ID_W-1:0]           m_id;
  logic                      m_ready;
  logic                      busy;
  logic [31:0]               pkt_cnt;

  sam_stream_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_last (m_last),
    .m_id   (m_id),
    .m_ready(m_ready),
    .busy   (busy),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
  } beat_t;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
    logic [ID_W-1:0]   id;
  } obeat_t;

  beat_t  src_q [NUM_REQ][$];
  beat_t  pend_q[NUM_REQ][$];
  obeat_t exp_q[$];
  int     out_cyc[$];
  bit     out_last[$];

  int total = 0;
  int bad   = 0;
  int pkt_model;
  int start_cyc[NUM_REQ];
  int mr_low_until;
  bit mr_rand;
  bit drop_en;
  int acc_low;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pkt(input int id, input int len, input logic [DATA_W-1:0] base, input bit rnd);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.d = rnd ? DATA_W'($urandom) : base + DATA_W'(k);
      b.l = (k == len - 1);
      src_q[id].push_back(b);
      pend_q[id].push_back(b);
    end
  endtask

  // Next whole packet of requester id is the next one expected on the output
  task automatic expect_pkt(input int id);
    beat_t  b;
    obeat_t o;
    while (pend_q[id].size() > 0) begin
      b    = pend_q[id].pop_front();
      o.d  = b.d;
      o.l  = b.l;
      o.id = ID_W'(id);
      exp_q.push_back(o);
      if (b.l) break;
    end
    pkt_model++;
  endtask

  // All requesters pending at once: plain round-robin over packets from ptr
  task automatic expect_rr(input int ptr);
    bit any;
    int c;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        c = (ptr + k) % NUM_REQ;
        if (pend_q[c].size() > 0) begin
          expect_pkt(c);
          ptr = (c + 1) % NUM_REQ;
          any = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pkt_model = 0;
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_q[i].delete();
      pend_q[i].delete();
      start_cyc[i] = 0;
    end
  endtask

  task automatic run(input string tag, input int max_cyc);
    bit     hold;
    bit     done;
    obeat_t prev;
    obeat_t e;
    bit     first[NUM_REQ];
    hold = 1'b0;
    prev = '0;
    acc_low = 0;
    out_cyc.delete();
    out_last.delete();
    for (int i = 0; i < NUM_REQ; i++) first[i] = 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (c >= start_cyc[i] && src_q[i].size() > 0) begin
          s_valid[i] = first[i] || !drop_en || ($urandom_range(3) != 0);
          s_data[i*DATA_W +: DATA_W] = src_q[i][0].d;
          s_last[i] = src_q[i][0].l;
        end else begin
          s_valid[i] = 1'b0;
          s_last[i]  = 1'b0;
        end
      end
      m_ready = (c < mr_low_until) ? 1'b0 : (mr_rand ? 1'($urandom_range(1)) : 1'b1);
      if (hold) begin
        check({tag, "_hold_data"}, 64'(m_data), 64'(prev.d));
        check({tag, "_hold_last"}, 64'(m_last), 64'(prev.l));
        check({tag, "_hold_id"},   64'(m_id),   64'(prev.id));
      end
      hold    = m_valid && !m_ready;
      prev.d  = m_data;
      prev.l  = m_last;
      prev.id = m_id;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_beat"}, 64'(m_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check({tag, "_data"}, 64'(m_data), 64'(e.d));
          check({tag, "_last"}, 64'(m_last), 64'(e.l));
          check({tag, "_id"},   64'(m_id),   64'(e.id));
          out_cyc.push_back(c);
          out_last.push_back(e.l);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (s_valid[i] && s_ready[i]) begin
          first[i] = src_q[i][0].l;
          void'(src_q[i].pop_front());
          if (c < mr_low_until) acc_low++;
        end
      end
      @(posedge clk);
      done = (exp_q.size() == 0);
      for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) done = 1'b0;
      if (done) break;
    end
    @(negedge clk);
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b1;
    check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(pkt_model));
  endtask

  initial begin
    rst          = 1'b1;
    s_valid      = '0;
    s_last       = '0;
    s_data       = '0;
    m_ready      = 1'b1;
    mr_low_until = 0;
    mr_rand      = 1'b0;
    drop_en      = 1'b0;
    pkt_model    = 0;
    for (int i = 0; i < NUM_REQ; i++) start_cyc[i] = 0;

    // Reset state while rst is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_busy",    64'(busy),    64'(0));
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_data",  64'(m_data),  64'(0));
    check("rst_m_last",  64'(m_last),  64'(0));
    check("rst_m_id",    64'(m_id),    64'(0));
    rst = 1'b0;

    // Three-beat packet from req0, cycle by cycle
    s_valid[0]   = 1'b1;
    s_data[31:0] = 32'h10;
    s_last[0]    = 1'b0;
    check("t1_ready_idle", 64'(s_ready), 64'(0));
    @(negedge clk);
    check("t1_ready_rise", 64'(s_ready), 64'(4'b0001));
    check("t1_busy",       64'(busy),    64'(1));
    @(negedge clk);
    s_data[31:0] = 32'h11;
    check("t1_b0_valid", 64'(m_valid), 64'(1));
    check("t1_b0_data",  64'(m_data),  64'(32'h10));
    check("t1_b0_id",    64'(m_id),    64'(0));
    check("t1_b0_last",  64'(m_last),  64'(0));
    @(negedge clk);
    s_data[31:0] = 32'h12;
    s_last[0]    = 1'b1;
    check("t1_b1_data", 64'(m_data), 64'(32'h11));
    check("t1_b1_last", 64'(m_last), 64'(0));
    @(negedge clk);
    s_valid = '0;
    s_last  = '0;
    check("t1_b2_data",  64'(m_data),  64'(32'h12));
    check("t1_b2_last",  64'(m_last),  64'(1));
    check("t1_idle",     64'(busy),    64'(0));
    check("t1_cnt_pre",  64'(pkt_cnt), 64'(0));
    @(negedge clk);
    check("t1_cnt_post", 64'(pkt_cnt), 64'(1));
    check("t1_empty",    64'(m_valid), 64'(0));
    pkt_model = 1;

    // Backpressure: only two beats absorbed while m_ready is low
    add_pkt(0, 5, 32'h20, 1'b0);
    expect_pkt(0);
    mr_low_until = 10;
    run("stall", 200);
    check("stall_accepted_low", 64'(acc_low), 64'(2));
    mr_low_until = 0;

    // All four requesting continuously with 2-beat packets
    do_reset();
    add_pkt(0, 2, 32'h1000, 1'b0);
    add_pkt(0, 2, 32'h1010, 1'b0);
    add_pkt(1, 2, 32'h1100, 1'b0);
    add_pkt(2, 2, 32'h1200, 1'b0);
    add_pkt(3, 2, 32'h1300, 1'b0);
    expect_pkt(0);
    expect_pkt(1);
    expect_pkt(2);
    expect_pkt(3);
    expect_pkt(0);
    run("rr4", 200);
    for (int j = 1; j < out_cyc.size(); j++) begin
      check("rr4_gap", 64'(out_cyc[j] - out_cyc[j-1]), 64'(out_last[j-1] ? 2 : 1));
    end

    // req1 and req3 arrive while req2 is mid-packet: req3 wins next
    do_reset();
    add_pkt(2, 4, 32'h300, 1'b0);
    add_pkt(1, 2, 32'h100, 1'b0);
    add_pkt(3, 2, 32'h400, 1'b0);
    start_cyc[1] = 3;
    start_cyc[3] = 3;
    expect_pkt(2);
    expect_pkt(3);
    expect_pkt(1);
    run("rr_skip", 200);
    start_cyc[1] = 0;
    start_cyc[3] = 0;

    // Single-beat packet from req1
    do_reset();
    add_pkt(1, 1, 32'h500, 1'b0);
    expect_pkt(1);
    run("single", 100);
    check("single_idle", 64'(busy), 64'(0));

    // Reset in the middle of a req2 packet (rr_ptr is 2 here)
    s_valid[2]       = 1'b1;
    s_data[64 +: 32] = 32'hA0;
    s_last[2]        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    s_data[64 +: 32] = 32'hA1;
    @(negedge clk);
    rst     = 1'b1;
    s_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    pkt_model = 0;
    check("mrst_m_valid", 64'(m_valid), 64'(0));
    check("mrst_busy",    64'(busy),    64'(0));
    check("mrst_pkt_cnt", 64'(pkt_cnt), 64'(0));
    check("mrst_s_ready", 64'(s_ready), 64'(0));
    add_pkt(1, 2, 32'h610, 1'b0);
    add_pkt(3, 2, 32'h630, 1'b0);
    expect_pkt(1);
    expect_pkt(3);
    run("after_rst", 200);

    // Randomized traffic: random lengths, data, valid gaps and m_ready
    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        add_pkt(i, int'($urandom_range(5, 1)), '0, 1'b1);
      end
    end
    expect_rr(0);
    mr_rand = 1'b1;
    drop_en = 1'b1;
    run("random", 5000);
    mr_rand = 1'b0;
    drop_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
